// File: rtl/arb_pkg.sv
// Shared types for the DM port arbiter: FSM state encoding, requester id
// type and the requester count.
package arb_pkg;

    localparam int NREQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    typedef logic req_id_t;

    // Lock-ownership state that corresponds to a given requester.
    function automatic arb_state_e own_state(input req_id_t id);
        return id ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/dm_rr_pick.sv
// Combinational grant selection for two requesters. A lock owner excludes
// the other requester; otherwise ties go to the requester that was not
// granted most recently.
module dm_rr_pick
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] valid_i,
    input  req_id_t         last_i,
    input  logic            own_valid_i,
    input  req_id_t         own_id_i,
    output logic [NREQ-1:0] grant_o
);

    // One-hot grant: owner-only while locked, round-robin on a tie otherwise.
    always_comb begin
        grant_o = '0;
        if (own_valid_i) begin
            grant_o[own_id_i] = valid_i[own_id_i];
        end else if (valid_i == 2'b11) begin
            grant_o[~last_i] = 1'b1;
        end else begin
            grant_o = valid_i;
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single-port data memory between the CPU load/store port
// (requester 0) and the DMA/debug loader port (requester 1). One access per
// cycle, round-robin fairness, bounded lock for short atomic sequences and a
// registered one-cycle response routed back to the requester that issued it.
module dm_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ-1:0]               req_write,
    input  logic [NREQ-1:0]               req_lock,
    input  logic [NREQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [NREQ-1:0][DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]               rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          DM_enable,
    output logic                          DM_write,
    output logic [ADDR_W-1:0]             DM_address,
    output logic [DATA_W-1:0]             DM_in,
    input  logic [DATA_W-1:0]             DM_out
);

    localparam int              CNT_W   = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

    arb_state_e       state_q;
    req_id_t          last_q;
    logic [CNT_W-1:0] lock_cnt_q;
    logic [CNT_W-1:0] lock_cnt_d;

    logic             rsp_pend_v_q;
    req_id_t          rsp_pend_id_q;
    logic             rsp_pend_rd_q;

    logic             own_valid;
    req_id_t          own_id;
    logic [NREQ-1:0]  pick_grant;
    logic [NREQ-1:0]  hs;
    logic             any_hs;
    req_id_t          hs_id;

    assign own_valid = (state_q != IDLE);
    assign own_id    = (state_q == OWN1);

    dm_rr_pick u_pick (
        .valid_i     (req_valid),
        .last_i      (last_q),
        .own_valid_i (own_valid),
        .own_id_i    (own_id),
        .grant_o     (pick_grant)
    );

    // No grant while reset is held, so the memory is never strobed then.
    assign req_ready = rst ? pick_grant : '0;
    assign hs        = req_valid & req_ready;
    assign any_hs    = |hs;
    assign hs_id     = hs[1];

    // Saturating lock counter increment for the owner's next handshake.
    assign lock_cnt_d = (lock_cnt_q == CNT_MAX) ? lock_cnt_q : lock_cnt_q + CNT_W'(1);

    // Drive the memory from whichever requester handshakes this cycle.
    always_comb begin
        DM_enable  = 1'b0;
        DM_write   = 1'b0;
        DM_address = '0;
        DM_in      = '0;
        if (any_hs) begin
            DM_enable  = 1'b1;
            DM_write   = req_write[hs_id];
            DM_address = req_addr[hs_id];
            DM_in      = req_wdata[hs_id];
        end
    end

    // Ownership FSM with round-robin history and lock-length counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
        end else begin
            if (any_hs) begin
                last_q <= hs_id;
            end
            case (state_q)
                IDLE: begin
                    if (any_hs && req_lock[hs_id]) begin
                        state_q    <= own_state(hs_id);
                        lock_cnt_q <= '0;
                    end
                end
                OWN0, OWN1: begin
                    if (!req_valid[own_id]) begin
                        state_q <= IDLE;
                    end else if (any_hs) begin
                        lock_cnt_q <= lock_cnt_d;
                        // Hitting the limit releases even if lock is still requested.
                        if ((lock_cnt_d == CNT_MAX) || !req_lock[own_id]) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pending-response flag; reset drops any access still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_pend_v_q <= 1'b0;
        end else begin
            rsp_pend_v_q <= any_hs;
        end
    end

    // Owner and access kind of the in-flight access, qualified by rsp_pend_v_q.
    always_ff @(posedge clk) begin
        if (any_hs) begin
            rsp_pend_id_q <= hs_id;
            rsp_pend_rd_q <= ~req_write[hs_id];
        end
    end

    // Route the completion to its owner; stores complete with zero data.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (rsp_pend_v_q) begin
            rsp_valid[rsp_pend_id_q] = 1'b1;
            if (rsp_pend_rd_q) begin
                rsp_rdata = DM_out;
            end
        end
    end

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Two-requester arbiter that shares the single-port data memory (DM: word-addressed, 1-cycle registered read) between the CPU load/store port (requester 0) and a DMA/debug loader port (requester 1). It sits between `top` and `DM`. It issues at most one DM access per cycle with round-robin fairness. An optional lock lets a requester keep the memory for short atomic sequences. It returns a registered response to the requester that owned each access.

## Interface
- `ADDR_W`, default 16: DM word-address width (matches `DM_address[17:2]`).
- `DATA_W`, default 32: data width.
- `MAX_LOCK`, default 8: maximum consecutive cycles a locked requester may hold the grant.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req_valid[1:0]` input 2: requester i has an access pending.
- `req_ready[1:0]` output 2: requester i is granted this cycle; a handshake is valid && ready.
- `req_write[1:0]` input 2: 1 = store, 0 = load.
- `req_lock[1:0]` input 2: requester i asks to keep the grant on the following cycle.
- `req_addr[2][ADDR_W]` input: word address.
- `req_wdata[2][DATA_W]` input: store data.
- `rsp_valid[1:0]` output 2: completion for requester i (loads and stores).
- `rsp_rdata[DATA_W]` output: load data; 0 for store completions.
- `DM_enable` output 1: memory access strobe.
- `DM_write` output 1: memory write strobe.
- `DM_address` output ADDR_W: memory word address.
- `DM_in` output DATA_W: memory write data.
- `DM_out` input DATA_W: memory read data, valid one cycle after a read enable.

## Operation
- State machine `{IDLE, OWN0, OWN1}`.
  - `IDLE`: no lock is held. The grant goes round-robin among valid requesters. `last` records the most recent grantee. On a tie, the requester that is not `last` wins.
  - `OWN0`/`OWN1`: entered when the granted requester handshakes with `req_lock=1`. In this state only that requester can be ready.
- Exit from `OWN*` to `IDLE` happens on any of these:
  - the owner handshakes with `req_lock=0`;
  - the owner drops `req_valid`;
  - `lock_cnt` reaches `MAX_LOCK`. This forced release makes the other requester win the next tie.
- `lock_cnt` behaviour:
  - clears on entry to `OWN*`;
  - increments on each owner handshake;
  - saturates at `MAX_LOCK`.
- Memory drive is combinational from the granted requester:
  - `DM_enable = |(req_valid & req_ready)`;
  - `DM_write`, `DM_address` and `DM_in` are muxed from that requester;
  - when there is no grant, all four are 0.
- Response path:
  - On a handshake, register `rsp_pend_id`, `rsp_pend_rd` and `rsp_pend_v`.
  - On the next cycle, `rsp_valid[id] = rsp_pend_v`.
  - `rsp_rdata = DM_out` when `rsp_pend_rd`, otherwise 0.
- Reset values: `last = 1`, so requester 0 wins the first tie. State is `IDLE`, `lock_cnt = 0` and `rsp_pend_v = 0`. As a result, `req_ready`, `rsp_valid`, `rsp_rdata` and all `DM_*` outputs are 0.

## Timing
- Grant latency is 0. `req_ready` is combinational from `req_valid`, the state and `last`. Requesters must not make `req_valid` depend on `req_ready`.
- Response latency: exactly 1 cycle after the handshake, for both loads and stores. Back-to-back handshakes give back-to-back responses.
- Throughput: one access per cycle. With both requesters continuously valid and unlocked, grants alternate 0, 1, 0, 1, ...
- A store followed by a load to the same address is ordered by grant order. The DM write completes at the edge, so the later load returns the new data.
- Reset asserted mid-operation: any pending response is dropped, with no `rsp_valid` after reset release. Any lock is released.
- Simultaneous events:
  - A forced release on the same cycle the owner requests lock again: the release wins.
  - `req_lock` without a handshake is ignored.

## Structure
- Package `arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_e`;
  - `typedef logic req_id_t`;
  - localparam `NREQ = 2`.
- Sub-module `dm_rr_pick` (combinational): takes valid[1:0], last, own_valid and own_id, and returns grant[1:0]. The top-level block holds the FSM, the counter and the response register.

## Test plan
- Reset, then r0 reads addr 0x0004 holding 0x1234_5678: `req_ready[0]=1` in the same cycle, and next cycle `rsp_valid=2'b01` with `rsp_rdata=0x1234_5678`.
- Both valid for 6 cycles, no lock: grant order 0, 1, 0, 1, 0, 1, each `rsp_valid` one cycle later to the correct requester.
- r1 writes 0xDEAD_BEEF to 0x0010, then r0 reads 0x0010: r0 receives 0xDEAD_BEEF, and r1's completion shows `rsp_rdata=0`.
- r1 holds `req_lock=1` with continuous valid while r0 is valid: r1 gets exactly `MAX_LOCK`+1 = 9 consecutive grants, then r0 is granted.
- r0 handshakes a read, then `rst` is driven low before the response cycle: `rsp_valid` stays 0 and all `DM_*` outputs are 0 during reset; after release, `last=1`.
- r0 locks, then drops `req_valid` while r1 is valid: return to `IDLE`, and r1 is granted the next cycle.
